instruction_fetch_stage: RTL

//  IF stage of the 5-stage MIPS pipeline: owns the PC and the instruction memory, and drives the
//  pc/instruction pair that the IF/ID register captures on the falling edge. Applies stalls from
//  the hazard unit and redirects from branch/jump logic, and detects the program-ending HALT word.
//  The debug unit loads the instruction memory through a write port while the pipeline is frozen.

---
 rtl/instruction_fetch_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of a 5-stage MIPS pipeline. It owns the PC and the
//               instruction memory, applies stall/redirect and detects HALT.
//               Optional fetch counter is enabled by defining FETCH_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDRWIDTH
`define ADDRWIDTH 32
`endif

module instruction_fetch_stage #(
    parameter int                 NB_DATA    = 32,
    parameter int                 NB_MEM     = 8,
    parameter logic [NB_DATA-1:0] HALT_INSTR = {NB_DATA{1'b1}},
    parameter int                 NB_COUNT   = 32
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  enable_pipe_i,
    input  logic                  stall_i,
    input  logic                  branch_taken_i,
    input  logic [`ADDRWIDTH-1:0] branch_addr_i,
    input  logic                  jump_i,
    input  logic [`ADDRWIDTH-1:0] jump_addr_i,
    input  logic                  wr_en_i,
    input  logic [NB_MEM-1:0]     wr_addr_i,
    input  logic [NB_DATA-1:0]    wr_data_i,
    output logic [`ADDRWIDTH-1:0] pc_o,
    output logic [NB_DATA-1:0]    instruction_o,
    output logic                  halt_o,
    output logic [NB_COUNT-1:0]   fetch_count_o
);

    localparam int c_NB_ADDR = `ADDRWIDTH;
    localparam int c_DEPTH   = 1 << NB_MEM;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t                 r_state;
    logic                   r_halt;
    logic [c_NB_ADDR-1:0]   r_pc;
    logic [NB_DATA-1:0]     r_mem [c_DEPTH];

    logic [NB_MEM-1:0]      w_rd_idx;
    logic [NB_DATA-1:0]     w_rd_word;
    logic [c_NB_ADDR-1:0]   w_pc_plus4;
    logic [c_NB_ADDR-1:0]   w_pc_next;
    logic                   w_advance;
    logic                   w_redirect;
    logic                   w_halt_fetch;

    // Byte-addressed PC; the low two bits never select a word.
    assign w_rd_idx     = r_pc[NB_MEM+1:2];
    assign w_rd_word    = r_mem[w_rd_idx];
    assign w_pc_plus4   = r_pc + c_NB_ADDR'(4);
    assign w_advance    = enable_pipe_i & ~stall_i & (r_state == ST_RUN);
    assign w_redirect   = branch_taken_i | jump_i;
    // A redirect means the HALT word is on the wrong path, so it must not stop us.
    assign w_halt_fetch = w_advance & ~w_redirect & (w_rd_word == HALT_INSTR);

    always_comb begin
        w_pc_next = w_pc_plus4;
        if (branch_taken_i) begin
            w_pc_next = branch_addr_i;
        end else if (jump_i) begin
            w_pc_next = jump_addr_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state <= ST_RUN;
            r_halt  <= 1'b0;
            r_pc    <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_fetch) begin
                        r_state <= ST_HALTED;
                        r_halt  <= 1'b1;
                    end else if (w_advance) begin
                        r_pc <= w_pc_next;
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                    r_halt  <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

    // Loading is independent of reset so the debug unit can write during it.
    always_ff @(posedge clock_i) begin
        if (wr_en_i && !enable_pipe_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign pc_o          = w_pc_plus4;
    assign instruction_o = (r_state == ST_HALTED) ? '0 : w_rd_word;
    assign halt_o        = r_halt;

`ifdef FETCH_COUNT_EN
    logic [NB_COUNT-1:0] r_fetch_count;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_fetch_count <= '0;
        end else if (w_advance && (r_fetch_count != {NB_COUNT{1'b1}})) begin
            r_fetch_count <= r_fetch_count + NB_COUNT'(1);
        end
    end

    assign fetch_count_o = r_fetch_count;
`else
    assign fetch_count_o = '0;
`endif

endmodule

`default_nettype wire
